serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 155 +++++++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b - bin.
// Each RUN cycle ripples one DIGIT-wide slice, LSB slice first. The borrow is
// held in a register between slices. diff, bout and ovf are valid while done is high.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               br_q, br_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               last;
  logic [DIGIT-1:0]   x_dig, y_dig;
  logic [DIGIT-1:0]   d_dig;
  logic               br_out;

  // Ripple of DIGIT full-subtractor cells; returns {borrow_out, difference}
  function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             br_in);
    logic             br;
    logic [DIGIT-1:0] d;
    br = br_in;
    d  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    return {br, d};
  endfunction

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == CNT_W'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: RUN ignores start; IDLE and DONE accept it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Select the operand slices addressed by the digit counter
  always_comb begin
    x_dig = '0;
    y_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        x_dig = a_q[i*DIGIT +: DIGIT];
        y_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  assign {br_out, d_dig} = sub_digit(x_dig, y_dig, br_q);

  // Datapath next state: capture on accept, otherwise one slice per RUN cycle
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    br_d   = br_q;
    diff_d = diff_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      br_d  = bin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (cnt_q == CNT_W'(i)) diff_d[i*DIGIT +: DIGIT] = d_dig;
      end
      br_d = br_out;
      if (last) begin
        cnt_d  = '0;
        bout_d = br_out;
        // Overflow only when operand signs differ and the result sign leaves a's sign
        ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_dig[DIGIT-1] != a_q[WIDTH-1]);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers; reset clears everything, including captured operands
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      br_q   <= br_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 16/4 directed and random checks, plus 3-bit
// exhaustive checks at DIGIT=1 and DIGIT=3, against an arithmetic reference.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-bit, DIGIT=4 instance
  logic        s16, bin16, busy16, done16, bout16, ovf16;
  logic [15:0] a16, b16, diff16;
  // 3-bit instances share stimulus
  logic        s3, bin3;
  logic [2:0]  a3, b3;
  logic        busy31, done31, bout31, ovf31;
  logic [2:0]  diff31;
  logic        busy33, done33, bout33, ovf33;
  logic [2:0]  diff33;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16));

  serial_subtractor #(.WIDTH(3), .DIGIT(1)) u31 (
    .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy31), .done(done31), .diff(diff31), .bout(bout31), .ovf(ovf31));

  serial_subtractor #(.WIDTH(3), .DIGIT(3)) u33 (
    .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy33), .done(done33), .diff(diff33), .bout(bout33), .ovf(ovf33));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, bout, diff} from integer arithmetic on the operands
  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
    int u, s;
    logic [15:0] d;
    u = int'(x) - int'(y) - int'(bi);
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
    d = u[15:0];
    return {(s > 32767) || (s < -32768), u < 0, d};
  endfunction

  function automatic logic [4:0] model3(input logic [2:0] x, input logic [2:0] y,
                                       input logic bi);
    int u, s;
    logic [2:0] d;
    u = int'(x) - int'(y) - int'(bi);
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
    d = u[2:0];
    return {(s > 3) || (s < -4), u < 0, d};
  endfunction

  task automatic chk16(input string tag, input logic [17:0] e);
    chk({tag, ".diff"}, 32'(diff16), 32'(e[15:0]));
    chk({tag, ".bout"}, 32'(bout16), 32'(e[16]));
    chk({tag, ".ovf"},  32'(ovf16),  32'(e[17]));
  endtask

  // Launch one operation on the 16-bit instance and check latency, busy and result
  task automatic run16(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic bi);
    logic [17:0] e;
    int cyc, nb;
    e = model16(x, y, bi);
    a16 = x; b16 = y; bin16 = bi; s16 = 1'b1;
    tick();
    s16 = 1'b0;
    cyc = 0; nb = 0;
    while (!done16 && cyc < 20) begin
      if (busy16) nb++;
      tick();
      cyc++;
    end
    chk({tag, ".lat"},  32'(cyc), 32'd4);
    chk({tag, ".busy"}, 32'(nb),  32'd4);
    chk({tag, ".done"}, 32'(done16), 32'd1);
    chk16(tag, e);
    tick();
    chk({tag, ".pulse"}, 32'(done16), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [17:0] e, e2;
    logic [4:0]  e3;
    logic [15:0] ra, rb;
    logic        rbi;
    int          cyc;
    logic        seen;

    rst = 1'b1; s16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    s3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
    // Start during reset must be ignored
    tick();
    s16 = 1'b1; a16 = 16'hFFFF;
    tick();
    s16 = 1'b0;
    chk("rst.busy", 32'(busy16), 32'd0);
    chk("rst.done", 32'(done16), 32'd0);
    chk16("rst", 18'd0);
    chk("rst.busy31", 32'(busy31), 32'd0);
    chk("rst.diff33", 32'(diff33), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst.idle", 32'(busy16), 32'd0);

    // Directed cases
    run16("basic",  16'h1234, 16'h0234, 1'b0);
    chk("basic.lit", 32'(diff16), 32'h1000);
    run16("under",  16'h0000, 16'h0001, 1'b0);
    chk("under.lit", 32'({ovf16, bout16, diff16}), 32'h1FFFF);
    run16("binw",   16'h0005, 16'h0005, 1'b1);
    chk("binw.lit", 32'({ovf16, bout16, diff16}), 32'h1FFFF);
    run16("ovfneg", 16'h8000, 16'h0001, 1'b0);
    chk("ovfneg.lit", 32'({ovf16, bout16, diff16}), 32'h27FFF);
    run16("ovfpos", 16'h7FFF, 16'hFFFF, 1'b0);
    chk("ovfpos.lit", 32'({ovf16, bout16, diff16}), 32'h38000);

    // Start pulsed with new operands during RUN is ignored
    a16 = 16'h1234; b16 = 16'h0234; bin16 = 1'b0; s16 = 1'b1;
    tick();
    s16 = 1'b0;
    tick();
    a16 = 16'hFFFF; b16 = 16'h0001; bin16 = 1'b1; s16 = 1'b1;
    tick();
    s16 = 1'b0;
    cyc = 2;
    while (!done16 && cyc < 20) begin tick(); cyc++; end
    chk("ign.lat", 32'(cyc), 32'd4);
    chk16("ign", model16(16'h1234, 16'h0234, 1'b0));
    tick();

    // Back-to-back: start held high in DONE
    e  = model16(16'hA5A5, 16'h1111, 1'b1);
    e2 = model16(16'h0100, 16'h0200, 1'b0);
    a16 = 16'hA5A5; b16 = 16'h1111; bin16 = 1'b1; s16 = 1'b1;
    tick();
    s16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 20) begin tick(); cyc++; end
    chk("b2b.first", 32'(done16), 32'd1);
    chk16("b2b1", e);
    a16 = 16'h0100; b16 = 16'h0200; bin16 = 1'b0; s16 = 1'b1;
    tick();
    s16 = 1'b0;
    chk("b2b.run", 32'(busy16), 32'd1);
    cyc = 1;
    while (!done16 && cyc < 20) begin tick(); cyc++; end
    chk("b2b.gap", 32'(cyc), 32'd5);
    chk16("b2b2", e2);
    tick();

    // Reset in the second cycle of RUN aborts with no done pulse
    a16 = 16'h4321; b16 = 16'h1234; bin16 = 1'b0; s16 = 1'b1;
    tick();
    s16 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", 32'(busy16), 32'd0);
    chk("abort.done", 32'(done16), 32'd0);
    chk16("abort", 18'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done16) seen = 1'b1;
      tick();
    end
    chk("abort.nodone", 32'(seen), 32'd0);
    run16("post", 16'h0010, 16'h0001, 1'b0);
    chk("post.lit", 32'(diff16), 32'h000F);

    // Random operands
    for (int k = 0; k < 40; k++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom);
      run16("rand", ra, rb, rbi);
    end

    // Exhaustive 3-bit at DIGIT=1 and DIGIT=3
    for (int i = 0; i < 128; i++) begin
      a3 = i[2:0]; b3 = i[5:3]; bin3 = i[6];
      e3 = model3(i[2:0], i[5:3], i[6]);
      s3 = 1'b1;
      tick();
      s3 = 1'b0;
      chk("x33.busy", 32'(busy33), 32'd1);
      tick();
      chk("x33.done", 32'(done33), 32'd1);
      chk("x33.res", 32'({ovf33, bout33, diff33}), 32'(e3));
      cyc = 1;
      while (!done31 && cyc < 10) begin tick(); cyc++; end
      chk("x31.lat", 32'(cyc), 32'd3);
      chk("x31.res", 32'({ovf31, bout31, diff31}), 32'(e3));
      chk("x33.hold", 32'({ovf33, bout33, diff33}), 32'(e3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
